seq_detect_n: RTL

Parametrised serial bit-pattern detector: samples one received bit `I` per qualified clock, compares the most recent `len` bits against a runtime-loaded pattern, pulses `activate` on each match and keeps a saturating match count. It is the next generation of the fixed one-hot detector driven from the receive bit stream, with programmable pattern, programmable length and selectable overlap behaviour.

---
 rtl/seq_detect_n.sv | 97 +++++++++
 1 files changed

// File: rtl/seq_detect_n.sv
// Serial pattern detector: programmable pattern/length, one-cycle match pulse, saturating count.
// Define SEQ_DETECT_OVERLAP_EN for overlapping detection; the default build restarts the window after a match.
module seq_detect_n #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     r,
    input  logic                     I,
    input  logic                     valid,
    input  logic                     load,
    input  logic [N-1:0]             pattern,
    input  logic [$clog2(N+1)-1:0]   len,
    output logic                     activate,
    output logic [CNT_W-1:0]         count,
    output logic [$clog2(N+1)-1:0]   fill
);
    localparam int LW = $clog2(N+1);

    logic [N-1:0]     pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [N-1:0]     hist_q, hist_d;
    logic [LW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             activate_q, activate_d;

    logic [N-1:0]     hist_sh;
    logic [N-1:0]     mask;
    logic [LW-1:0]    fill_inc;
    logic             len_ok;
    logic             match;

    always_comb begin
        pat_d      = pat_q;
        len_d      = len_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        count_d    = count_q;
        activate_d = 1'b0;

        hist_sh = {hist_q[N-2:0], I};
        len_ok  = (len_q != '0) && ({1'b0, len_q} <= (LW+1)'(N));
        for (int i = 0; i < N; i++) begin
            mask[i] = (LW'(i) < len_q);
        end
        // An unusable length keeps fill pinned at zero so the detector stays disarmed
        if (!len_ok)
            fill_inc = '0;
        else if (fill_q >= len_q)
            fill_inc = len_q;
        else
            fill_inc = fill_q + LW'(1);
        match = len_ok && (fill_inc == len_q) && (((hist_sh ^ pat_q) & mask) == '0);

        if (load) begin
            pat_d   = pattern;
            len_d   = len;
            hist_d  = '0;
            fill_d  = '0;
            count_d = '0;
        end else if (valid) begin
            hist_d = hist_sh;
            fill_d = fill_inc;
            if (match) begin
                activate_d = 1'b1;
                if (!(&count_q))
                    count_d = count_q + CNT_W'(1);
`ifndef SEQ_DETECT_OVERLAP_EN
                fill_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            pat_q      <= '0;
            len_q      <= '0;
            hist_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            activate_q <= 1'b0;
        end else begin
            pat_q      <= pat_d;
            len_q      <= len_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            activate_q <= activate_d;
        end
    end

    assign activate = activate_q;
    assign count    = count_q;
    assign fill     = fill_q;

endmodule
